// File: rtl/sme_rng_dispenser.sv
// ---------------------------------------------------------------------------
// sme_rng_dispenser
//
// Consumer end of the SME random-mask interface. Requests a new RNG state with
// a one-cycle rng_update pulse, snapshots the RMAX x XLEN guard-share bus into
// a local buffer and hands out one fresh XLEN-bit mask word per handshake.
// A word is zeroed in the buffer the moment it is consumed, and the buffer is
// only refilled when exhausted or flushed, so no word is ever delivered twice.
//
// Optional build macro: SME_RNG_PREFETCH_EN
//   Adds a shadow buffer that is refilled in the background while serving,
//   so the primary buffer can be reloaded without a refill bubble.
//
// Ports:
//   g_clk       in   clock
//   g_reset     in   asynchronous active-high reset
//   g_clk_req   out  clock request (low only when idle in SERVE)
//   rng_update  out  one-cycle update request to the RNG
//   rng_in      in   RNG output bus, word i = rng_in[i*XLEN +: XLEN]
//   req_valid   in   consumer wants a mask word
//   req_ready   out  a fresh word is presented
//   req_data    out  mask word (zero when req_ready is low)
//   flush       in   discard all buffered words and refill
//   avail       out  number of fresh words in the primary buffer
//
// State table (primary sequencer):
//   state      | meaning
//   EMPTY      | buffer empty after reset, refill starts next cycle
//   REFRESH    | rng_update issued, wait counter loaded
//   WAIT       | waiting UPD_LAT cycles for rng_in to settle
//   CAPTURE    | buffer loaded from rng_in
//   SERVE      | words handed out on handshakes
// ---------------------------------------------------------------------------
module sme_rng_dispenser #(
    parameter int XLEN    = 32,
    parameter int SMAX    = 3,
    parameter int UPD_LAT = 1,
    localparam int RMAX   = SMAX + SMAX * (SMAX - 1) / 2,
    localparam int AW     = $clog2(RMAX + 1)
) (
    input  logic                 g_clk,
    input  logic                 g_reset,
    output logic                 g_clk_req,
    output logic                 rng_update,
    input  logic [RMAX*XLEN-1:0] rng_in,
    input  logic                 req_valid,
    output logic                 req_ready,
    output logic [XLEN-1:0]      req_data,
    input  logic                 flush,
    output logic [AW-1:0]        avail
);

    localparam int CW = $clog2(UPD_LAT + 1);

    typedef enum logic [2:0] {
        ST_EMPTY,
        ST_REFRESH,
        ST_WAIT,
        ST_CAPTURE,
        ST_SERVE
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [AW-1:0]     ptr_q, ptr_d;
    logic [AW-1:0]     avail_q, avail_d;
    logic [XLEN-1:0]   buf_q [RMAX];
    logic [XLEN-1:0]   buf_d [RMAX];
    logic [XLEN-1:0]   word_sel;
    logic              upd_p;
    logic              hs;

`ifdef SME_RNG_PREFETCH_EN
    typedef enum logic [1:0] {
        SH_IDLE,
        SH_REFRESH,
        SH_WAIT,
        SH_CAPTURE
    } sh_state_t;

    sh_state_t         sh_state_q, sh_state_d;
    logic [CW-1:0]     sh_cnt_q, sh_cnt_d;
    logic              sh_valid_q, sh_valid_d;
    logic [XLEN-1:0]   sh_buf_q [RMAX];
    logic [XLEN-1:0]   sh_buf_d [RMAX];
    logic              sh_upd;
    logic              xfer;
`endif

    // Flush blocks the handshake in the same cycle.
    assign req_ready = (state_q == ST_SERVE) && (avail_q != '0) && !flush;
    assign hs        = req_valid && req_ready;

    always_comb begin
        word_sel = '0;
        for (int i = 0; i < RMAX; i++) begin
            if (ptr_q == AW'(i)) begin
                word_sel = buf_q[i];
            end
        end
    end

    assign req_data = req_ready ? word_sel : '0;
    assign avail    = avail_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        avail_d = avail_q;
        buf_d   = buf_q;
        upd_p   = 1'b0;

        case (state_q)
            ST_EMPTY: begin
                state_d = ST_REFRESH;
            end
            ST_REFRESH: begin
                upd_p   = 1'b1;
                cnt_d   = CW'(UPD_LAT);
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                for (int i = 0; i < RMAX; i++) begin
                    buf_d[i] = rng_in[i*XLEN +: XLEN];
                end
                ptr_d   = '0;
                avail_d = AW'(RMAX);
                state_d = ST_SERVE;
            end
            ST_SERVE: begin
                if (hs) begin
                    for (int i = 0; i < RMAX; i++) begin
                        if (ptr_q == AW'(i)) begin
                            buf_d[i] = '0;
                        end
                    end
                    ptr_d   = ptr_q + AW'(1);
                    avail_d = avail_q - AW'(1);
                    if (avail_q == AW'(1)) begin
`ifdef SME_RNG_PREFETCH_EN
                        if (sh_valid_q) begin
                            buf_d   = sh_buf_q;
                            ptr_d   = '0;
                            avail_d = AW'(RMAX);
                        end else begin
                            state_d = ST_REFRESH;
                        end
`else
                        state_d = ST_REFRESH;
`endif
                    end
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase

        if (flush) begin
            state_d = ST_REFRESH;
            ptr_d   = '0;
            avail_d = '0;
            for (int i = 0; i < RMAX; i++) begin
                buf_d[i] = '0;
            end
        end
    end

`ifdef SME_RNG_PREFETCH_EN
    assign xfer = hs && (avail_q == AW'(1)) && sh_valid_q;

    always_comb begin
        sh_state_d = sh_state_q;
        sh_cnt_d   = sh_cnt_q;
        sh_valid_d = sh_valid_q;
        sh_buf_d   = sh_buf_q;
        sh_upd     = 1'b0;

        case (sh_state_q)
            SH_IDLE: begin
                if ((state_q == ST_SERVE) && !sh_valid_q) begin
                    sh_state_d = SH_REFRESH;
                end
            end
            SH_REFRESH: begin
                sh_upd     = 1'b1;
                sh_cnt_d   = CW'(UPD_LAT);
                sh_state_d = SH_WAIT;
            end
            SH_WAIT: begin
                sh_cnt_d = sh_cnt_q - CW'(1);
                if (sh_cnt_q == CW'(1)) begin
                    sh_state_d = SH_CAPTURE;
                end
            end
            SH_CAPTURE: begin
                for (int i = 0; i < RMAX; i++) begin
                    sh_buf_d[i] = rng_in[i*XLEN +: XLEN];
                end
                sh_valid_d = 1'b1;
                sh_state_d = SH_IDLE;
            end
            default: begin
                sh_state_d = SH_IDLE;
            end
        endcase

        if (xfer) begin
            sh_valid_d = 1'b0;
        end

        // Whenever the primary leaves SERVE it issues its own update; a
        // half-finished shadow fill would then capture that same RNG state.
        if (state_d != ST_SERVE) begin
            sh_state_d = SH_IDLE;
        end

        if (flush) begin
            sh_state_d = SH_IDLE;
            sh_valid_d = 1'b0;
            for (int i = 0; i < RMAX; i++) begin
                sh_buf_d[i] = '0;
            end
        end
    end

    assign rng_update = upd_p || sh_upd;
    assign g_clk_req  = !g_reset && ((state_q != ST_SERVE) || req_valid ||
                                     (sh_state_q != SH_IDLE) || !sh_valid_q);

    always_ff @(posedge g_clk or posedge g_reset) begin
        if (g_reset) begin
            sh_state_q <= SH_IDLE;
            sh_cnt_q   <= '0;
            sh_valid_q <= 1'b0;
            for (int i = 0; i < RMAX; i++) begin
                sh_buf_q[i] <= '0;
            end
        end else begin
            sh_state_q <= sh_state_d;
            sh_cnt_q   <= sh_cnt_d;
            sh_valid_q <= sh_valid_d;
            sh_buf_q   <= sh_buf_d;
        end
    end
`else
    assign rng_update = upd_p;
    // Reset gates the request directly so it drops without a clock edge.
    assign g_clk_req  = !g_reset && ((state_q != ST_SERVE) || req_valid);
`endif

    always_ff @(posedge g_clk or posedge g_reset) begin
        if (g_reset) begin
            state_q <= ST_EMPTY;
            cnt_q   <= '0;
            ptr_q   <= '0;
            avail_q <= '0;
            for (int i = 0; i < RMAX; i++) begin
                buf_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            avail_q <= avail_d;
            buf_q   <= buf_d;
        end
    end

endmodule

// File: tb/tb_sme_rng_dispenser.sv
module tb_sme_rng_dispenser;

    localparam int XLEN = 32;
    localparam int RMAX = 6;
    localparam int AW   = 3;

    logic                 g_clk = 1'b0;
    logic                 g_reset = 1'b1;
    logic [RMAX*XLEN-1:0] rng_in;

    logic                 g_clk_req, rng_update, req_valid, req_ready, flush;
    logic [XLEN-1:0]      req_data;
    logic [AW-1:0]        avail;

    logic                 g_clk_req3, rng_update3, req_valid3, req_ready3, flush3;
    logic [XLEN-1:0]      req_data3;
    logic [AW-1:0]        avail3;

    int total = 0;
    int bad = 0;
    int pulses = 0;
    int gen = 0;
    bit rng_auto = 1'b0;

    sme_rng_dispenser #(.XLEN(XLEN), .SMAX(3), .UPD_LAT(1)) dut (
        .g_clk(g_clk), .g_reset(g_reset), .g_clk_req(g_clk_req),
        .rng_update(rng_update), .rng_in(rng_in), .req_valid(req_valid),
        .req_ready(req_ready), .req_data(req_data), .flush(flush), .avail(avail)
    );

    sme_rng_dispenser #(.XLEN(XLEN), .SMAX(3), .UPD_LAT(3)) dut3 (
        .g_clk(g_clk), .g_reset(g_reset), .g_clk_req(g_clk_req3),
        .rng_update(rng_update3), .rng_in(rng_in), .req_valid(req_valid3),
        .req_ready(req_ready3), .req_data(req_data3), .flush(flush3), .avail(avail3)
    );

    always #5 g_clk = ~g_clk;

    always @(negedge g_clk) begin
        if (rng_update) pulses++;
    end

    task automatic set_rng(input logic [31:0] base);
        for (int i = 0; i < RMAX; i++) begin
            rng_in[i*XLEN +: XLEN] = base + 32'(i);
        end
    endtask

    // Advance one cycle; sample point is 1 time unit after the rising edge.
    // With rng_auto set, an RNG model with one cycle of latency presents a
    // new state (generation number in the top nibble) after each pulse.
    task automatic step;
        logic was;
        was = rng_update;
        @(posedge g_clk);
        #1;
        if (rng_auto && was) begin
            gen++;
            set_rng(32'(gen) << 28);
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        req_valid  = 1'b0;
        flush      = 1'b0;
        req_valid3 = 1'b0;
        flush3     = 1'b0;
        set_rng(32'h1000_0000);
`ifdef SME_RNG_PREFETCH_EN
        rng_auto = 1'b1;
`endif
        step;
        step;
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_data", req_data, 32'd0);
        chk("rst_avail", 32'(avail), 32'd0);
        chk("rst_upd", 32'(rng_update), 32'd0);
        chk("rst_clkreq", 32'(g_clk_req), 32'd0);

        // cycle 0: reset released
        g_reset = 1'b0;
        #1;
        chk("c0_upd", 32'(rng_update), 32'd0);
        chk("c0_clkreq", 32'(g_clk_req), 32'd1);
        step;
        chk("c1_upd", 32'(rng_update), 32'd1);
        chk("c1_upd3", 32'(rng_update3), 32'd1);
        step;
        chk("c2_upd", 32'(rng_update), 32'd0);
        chk("c2_ready", 32'(req_ready), 32'd0);
        step;
        chk("c3_ready", 32'(req_ready), 32'd0);
        chk("c3_upd3", 32'(rng_update3), 32'd0);
        step;
        chk("c4_ready", 32'(req_ready), 32'd1);
        chk("c4_avail", 32'(avail), 32'd6);
        chk("c4_data", req_data, 32'h1000_0000);
        chk("c4_ready3", 32'(req_ready3), 32'd0);
        step;
        chk("lat3_c5_ready", 32'(req_ready3), 32'd0);
        chk("lat3_c5_avail", 32'(avail3), 32'd0);
`ifndef SME_RNG_PREFETCH_EN
        chk("idle_upd", 32'(rng_update), 32'd0);
`endif
        step;
        chk("lat3_c6_ready", 32'(req_ready3), 32'd1);
        chk("lat3_c6_avail", 32'(avail3), 32'd6);
        chk("lat3_c6_data", req_data3, 32'h1000_0000);
        chk("idle_avail", 32'(avail), 32'd6);
`ifndef SME_RNG_PREFETCH_EN
        chk("idle_clkreq", 32'(g_clk_req), 32'd0);
`endif

`ifdef SME_RNG_PREFETCH_EN
        // 18 back-to-back handshakes; word n belongs to capture n/6.
        req_valid = 1'b1;
        for (int n = 0; n < 18; n++) begin
            chk("pf_ready", 32'(req_ready), 32'd1);
            chk("pf_data", req_data, ((32'(n / 6) + 32'd1) << 28) + 32'(n % 6));
            if (n == 12) chk("pf_pulses", 32'(pulses), 32'd3);
            step;
        end
        req_valid = 1'b0;
        rng_auto  = 1'b0;
`else
        // Drain six words, then refill from a new RNG state.
        req_valid = 1'b1;
        set_rng(32'h3000_0000);
        for (int k = 0; k < 6; k++) begin
            chk("dr_ready", 32'(req_ready), 32'd1);
            chk("dr_data", req_data, 32'h1000_0000 + 32'(k));
            chk("dr_avail", 32'(avail), 32'(6 - k));
            step;
        end
        chk("dr_empty_ready", 32'(req_ready), 32'd0);
        chk("dr_empty_avail", 32'(avail), 32'd0);
        chk("dr_upd", 32'(rng_update), 32'd1);
        step;
        chk("dr_wait_upd", 32'(rng_update), 32'd0);
        step;
        chk("dr_cap_ready", 32'(req_ready), 32'd0);
        step;
        chk("dr_new_ready", 32'(req_ready), 32'd1);
        chk("dr_new_data", req_data, 32'h3000_0000);
        chk("dr_new_avail", 32'(avail), 32'd6);

        // Two handshakes, then flush together with req_valid.
        step;
        chk("fl_hs1_data", req_data, 32'h3000_0001);
        step;
        chk("fl_hs2_avail", 32'(avail), 32'd4);
        flush = 1'b1;
        set_rng(32'h2000_0000);
        #1;
        chk("fl_ready", 32'(req_ready), 32'd0);
        chk("fl_data", req_data, 32'd0);
        step;
        flush = 1'b0;
        chk("fl_avail", 32'(avail), 32'd0);
        chk("fl_upd", 32'(rng_update), 32'd1);
        step;
        step;
        chk("fl_cap_ready", 32'(req_ready), 32'd0);
        step;
        chk("fl_new_data", req_data, 32'h2000_0000);
        chk("fl_new_avail", 32'(avail), 32'd6);
        req_valid = 1'b0;
`endif

        // Async reset asserted between edges while in WAIT.
        flush = 1'b1;
        step;
        flush = 1'b0;
        chk("ar_refresh_upd", 32'(rng_update), 32'd1);
        step;
        chk("ar_wait_upd", 32'(rng_update), 32'd0);
        set_rng(32'h5000_0000);
        #3;
        g_reset = 1'b1;
        #1;
        chk("ar_ready", 32'(req_ready), 32'd0);
        chk("ar_data", req_data, 32'd0);
        chk("ar_avail", 32'(avail), 32'd0);
        chk("ar_upd", 32'(rng_update), 32'd0);
        chk("ar_clkreq", 32'(g_clk_req), 32'd0);
        chk("ar_ready3", 32'(req_ready3), 32'd0);
        chk("ar_data3", req_data3, 32'd0);
        chk("ar_avail3", 32'(avail3), 32'd0);
        step;
        chk("ar_next_upd", 32'(rng_update), 32'd0);
        g_reset = 1'b0;
        step;
        chk("rf_c1_upd", 32'(rng_update), 32'd1);
        step;
        step;
        chk("rf_c3_ready", 32'(req_ready), 32'd0);
        step;
        chk("rf_c4_ready", 32'(req_ready), 32'd1);
        chk("rf_c4_data", req_data, 32'h5000_0000);
        chk("rf_c4_avail", 32'(avail), 32'd6);
        step;
        chk("rf3_c5_ready", 32'(req_ready3), 32'd0);
        step;
        chk("rf3_c6_ready", 32'(req_ready3), 32'd1);
        chk("rf3_c6_data", req_data3, 32'h5000_0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
